// File: rtl/dmi_core_responder.sv
// Core-side DMI responder: forwards synchronizer strobes to the debug module, returns data/status + toggle.
// Latency: reg_en N -> dm_req_valid N+1; dm_rsp_valid M -> rsp_*/rsp_toggle M+1; sticky-busy reply at N+1.
// Backpressure: dm_req_valid holds until dm_req_ready or timeout; strobes arriving while busy are dropped as overrun.
module dmi_core_responder #(
    parameter int TIMEOUT = 256,
    parameter int AW      = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          reg_en,
    input  logic          reg_wr_en,
    input  logic [AW-1:0] reg_addr,
    input  logic [31:0]   reg_wdata,
    input  logic          clr_err,
    output logic          dm_req_valid,
    input  logic          dm_req_ready,
    output logic          dm_req_write,
    output logic [AW-1:0] dm_req_addr,
    output logic [31:0]   dm_req_wdata,
    input  logic          dm_rsp_valid,
    input  logic [31:0]   dm_rsp_rdata,
    output logic [31:0]   rsp_rdata,
    output logic [1:0]    rsp_status,
    output logic          rsp_toggle,
    output logic          busy,
    output logic          err_sticky
);

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          sticky_busy;
    logic          overrun;
    logic          expired;
    logic          done_ok;
    logic          done_to;

    always_comb begin
        accept      = 1'b0;
        sticky_busy = 1'b0;
        overrun     = 1'b0;
        done_ok     = 1'b0;
        done_to     = 1'b0;
        expired     = (cnt == CNT_MAX);
        state_nxt   = state;
        case (state)
            S_IDLE: begin
                if (reg_en && !err_sticky) begin
                    accept    = 1'b1;
                    state_nxt = S_REQ;
                end else if (reg_en) begin
                    sticky_busy = 1'b1;
                end
            end
            S_REQ: begin
                overrun = reg_en;
                // A handshake in the expiry cycle wins; the saturated count then expires WAIT next cycle.
                if (dm_req_ready) begin
                    state_nxt = S_WAIT;
                end else if (expired) begin
                    done_to   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                overrun = reg_en;
                if (dm_rsp_valid) begin
                    done_ok   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (expired) begin
                    done_to   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            dm_req_valid <= 1'b0;
            cnt          <= '0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt != S_IDLE);
            dm_req_valid <= (state_nxt == S_REQ);
            if (accept) begin
                cnt <= '0;
            end else if (state != S_IDLE && !expired) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_req_write <= 1'b0;
            dm_req_addr  <= '0;
            dm_req_wdata <= '0;
        end else if (accept) begin
            dm_req_write <= reg_wr_en;
            dm_req_addr  <= reg_addr;
            dm_req_wdata <= reg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata  <= '0;
            rsp_status <= 2'd0;
            rsp_toggle <= 1'b0;
        end else if (done_ok) begin
            rsp_status <= 2'd0;
            rsp_toggle <= ~rsp_toggle;
            if (!dm_req_write) begin
                rsp_rdata <= dm_rsp_rdata;
            end
        end else if (done_to) begin
            rsp_status <= 2'd2;
            rsp_toggle <= ~rsp_toggle;
        end else if (sticky_busy) begin
            rsp_status <= 2'd3;
            rsp_toggle <= ~rsp_toggle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (overrun) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmi_core_responder.sv
// Bench for dmi_core_responder: transaction-level expectations from per-access timing arithmetic.
// Inputs are driven and outputs observed on the falling edge; the DUT samples on the rising edge.
module tb_dmi_core_responder;

    localparam int T  = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          reg_en;
    logic          reg_wr_en;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata;
    logic          clr_err;
    logic          dm_req_valid;
    logic          dm_req_ready;
    logic          dm_req_write;
    logic [AW-1:0] dm_req_addr;
    logic [31:0]   dm_req_wdata;
    logic          dm_rsp_valid;
    logic [31:0]   dm_rsp_rdata;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_status;
    logic          rsp_toggle;
    logic          busy;
    logic          err_sticky;

    int            n_checks = 0;
    int            n_errors = 0;

    logic [31:0]   exp_rdata;
    logic [1:0]    exp_status;
    logic          exp_toggle;
    logic          exp_sticky;

    dmi_core_responder #(.TIMEOUT(T), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_en       (reg_en),
        .reg_wr_en    (reg_wr_en),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .clr_err      (clr_err),
        .dm_req_valid (dm_req_valid),
        .dm_req_ready (dm_req_ready),
        .dm_req_write (dm_req_write),
        .dm_req_addr  (dm_req_addr),
        .dm_req_wdata (dm_req_wdata),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rsp_rdata (dm_rsp_rdata),
        .rsp_rdata    (rsp_rdata),
        .rsp_status   (rsp_status),
        .rsp_toggle   (rsp_toggle),
        .busy         (busy),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        chk({tag, "_toggle"}, 32'(rsp_toggle), 32'(exp_toggle));
        chk({tag, "_status"}, 32'(rsp_status), 32'(exp_status));
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_sticky"}, 32'(err_sticky), 32'(exp_sticky));
    endtask

    // One access from the JTAG side. d = cycles dm_req_ready is withheld after REQ entry,
    // r = extra cycles after the handshake before the DM answers (if respond).
    task automatic run_access(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int d, input logic respond, input int r,
                              input logic do_ov, input logic ov_clr);
        int   e, h, m, c, vend, last, o, lim;
        logic hs, ok, junk_ok;
        reg_wr_en = wr;
        reg_addr  = addr;
        reg_wdata = wdata;
        if (exp_sticky) begin
            reg_en = 1'b1;
            @(negedge clk);
            reg_en     = 1'b0;
            reg_wr_en  = 1'b0;
            exp_toggle = ~exp_toggle;
            exp_status = 2'd3;
            chk("sb_valid", 32'(dm_req_valid), 32'd0);
            chk("sb_busy", 32'(busy), 32'd0);
            check_rsp("sb");
            return;
        end
        e    = 1;
        hs   = (d <= T - 1);
        h    = e + d;
        m    = h + 1 + r;
        lim  = (e + T - 1 > h + 1) ? e + T - 1 : h + 1;
        ok   = hs && respond && (m <= lim);
        if (ok)      c = m + 1;
        else if (hs) c = (h + 2 > e + T) ? h + 2 : e + T;
        else         c = e + T;
        vend = hs ? h : e + T - 1;
        last = c + 1;
        if (hs && respond && m + 1 > last) last = m + 1;
        o    = e + $urandom_range(0, c - 1 - e);
        for (int t = 0; t <= last; t++) begin
            if (t > 0) begin
                if (do_ov && t == o + 1) exp_sticky = 1'b1;
                if (t == c) begin
                    exp_toggle = ~exp_toggle;
                    exp_status = ok ? 2'd0 : 2'd2;
                    if (ok && !wr) exp_rdata = rdata;
                end
                chk("valid", 32'(dm_req_valid), 32'(t >= e && t <= vend));
                chk("busy", 32'(busy), 32'(t >= e && t < c));
                check_rsp("acc");
                if (t == e) begin
                    chk("req_addr", 32'(dm_req_addr), 32'(addr));
                    chk("req_write", 32'(dm_req_write), 32'(wr));
                    chk("req_wdata", dm_req_wdata, wdata);
                end
            end
            reg_en       = (t == 0) || (do_ov && t == o);
            reg_wr_en    = (t == 0) ? wr : 1'($urandom_range(0, 1));
            clr_err      = do_ov && ov_clr && (t == o);
            dm_req_ready = hs && (t >= e + d) && (t <= h);
            junk_ok      = !(hs && t > h && t < c);
            dm_rsp_valid = (respond && hs && t == m) || (junk_ok && $urandom_range(0, 3) == 0);
            dm_rsp_rdata = (t == m) ? rdata : $urandom;
            @(negedge clk);
        end
        reg_en       = 1'b0;
        reg_wr_en    = 1'b0;
        clr_err      = 1'b0;
        dm_req_ready = 1'b0;
        dm_rsp_valid = 1'b0;
    endtask

    task automatic idle_gap(input int n, input logic clr);
        for (int i = 0; i < n; i++) begin
            clr_err      = clr && (i == 0);
            dm_rsp_valid = ($urandom_range(0, 2) == 0);
            dm_rsp_rdata = $urandom;
            @(negedge clk);
            if (clr && i == 0) exp_sticky = 1'b0;
            clr_err      = 1'b0;
            dm_rsp_valid = 1'b0;
            chk("gap_busy", 32'(busy), 32'd0);
            chk("gap_valid", 32'(dm_req_valid), 32'd0);
            check_rsp("gap");
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(dm_req_valid), 32'd0);
        chk({tag, "_write"}, 32'(dm_req_write), 32'd0);
        chk({tag, "_addr"}, 32'(dm_req_addr), 32'd0);
        chk({tag, "_wdata"}, dm_req_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        check_rsp(tag);
    endtask

    initial begin
        rst_n        = 1'b0;
        reg_en       = 1'b0;
        reg_wr_en    = 1'b0;
        reg_addr     = '0;
        reg_wdata    = '0;
        clr_err      = 1'b0;
        dm_req_ready = 1'b0;
        dm_rsp_valid = 1'b0;
        dm_rsp_rdata = '0;
        exp_rdata    = '0;
        exp_status   = 2'd0;
        exp_toggle   = 1'b0;
        exp_sticky   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // directed scenarios
        run_access(1'b0, 7'h11, 32'h0, 32'hDEADBEEF, 0, 1'b1, 0, 1'b0, 1'b0);
        run_access(1'b0, 7'h22, 32'h0, 32'hA5A5A5A5, 2, 1'b1, 1, 1'b0, 1'b0);
        run_access(1'b1, 7'h10, 32'h12345678, 32'h0BADF00D, 5, 1'b1, 0, 1'b0, 1'b0);
        run_access(1'b0, 7'h04, 32'h0, 32'h77777777, 0, 1'b1, 10, 1'b0, 1'b0);
        run_access(1'b0, 7'h05, 32'h0, 32'h66666666, T, 1'b0, 0, 1'b0, 1'b0);
        run_access(1'b0, 7'h06, 32'h0, 32'h55AA55AA, T - 1, 1'b1, 0, 1'b0, 1'b0);
        run_access(1'b0, 7'h07, 32'h0, 32'h13572468, 0, 1'b1, 3, 1'b1, 1'b0);
        run_access(1'b0, 7'h08, 32'h0, 32'hFFFFFFFF, 0, 1'b1, 0, 1'b0, 1'b0);
        idle_gap(1, 1'b1);
        run_access(1'b0, 7'h09, 32'h0, 32'h24681357, 1, 1'b1, 1, 1'b0, 1'b0);
        run_access(1'b1, 7'h0A, 32'hCAFEF00D, 32'h0, 0, 1'b1, 2, 1'b1, 1'b1);
        idle_gap(2, 1'b0);
        idle_gap(1, 1'b1);

        // asynchronous reset while waiting for the DM
        reg_en = 1'b1; reg_wr_en = 1'b1; reg_addr = 7'h3C; reg_wdata = 32'h89ABCDEF;
        @(negedge clk);
        reg_en = 1'b0; dm_req_ready = 1'b1;
        @(negedge clk);
        dm_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_rdata  = '0;
        exp_status = 2'd0;
        exp_toggle = 1'b0;
        exp_sticky = 1'b0;
        check_reset_values("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_access(1'b0, 7'h2B, 32'h0, 32'h31415926, 0, 1'b1, 0, 1'b0, 1'b0);
        chk("post_rst_toggle", 32'(rsp_toggle), 32'd1);

        // randomized accesses
        for (int i = 0; i < 150; i++) begin
            run_access(1'($urandom_range(0, 1)), 7'($urandom), $urandom, $urandom,
                       $urandom_range(0, T), ($urandom_range(0, 4) != 0), $urandom_range(0, T),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1));
            idle_gap($urandom_range(1, 3), ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmi_core_responder.md
# dmi_core_responder

Core-clock-domain responder for DMI accesses. It accepts the single-cycle read/write strobes produced by the JTAG-to-core synchronizer and forwards each one to the debug module over a valid/ready request channel. It waits for the debug module's response, or times out. It then returns read data and status to the JTAG side as quasi-static registers plus a completion toggle that the TCK domain synchronizes.

## Interface
- `TIMEOUT`, 256: max cycles a request may spend in REQ+WAIT before a forced failure completion; legal range 2..65535.
- `AW`, 7: DMI address width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: core clock.
- `rst_n` in 1: async active-low reset.
- `reg_en` in 1: one-cycle access strobe from synchronizer.
- `reg_wr_en` in 1: one-cycle write qualifier, valid with `reg_en`.
- `reg_addr` in AW: DMI address; stable, JTAG-held, sampled on `reg_en`.
- `reg_wdata` in 32: write data; stable, sampled on `reg_en`.
- `clr_err` in 1: one-cycle pulse (synchronized dmireset) clearing `err_sticky`.
- `dm_req_valid` out 1: request to debug module.
- `dm_req_ready` in 1: debug module accepts request.
- `dm_req_write` out 1: 1 = write.
- `dm_req_addr` out AW: captured address.
- `dm_req_wdata` out 32: captured write data.
- `dm_rsp_valid` in 1: one-cycle response strobe.
- `dm_rsp_rdata` in 32: read data, valid with `dm_rsp_valid`.
- `rsp_rdata` out 32: last read result, held until next read completion.
- `rsp_status` out 2: 0 = success, 2 = failed (timeout), 3 = busy/overrun.
- `rsp_toggle` out 1: inverts once per completion.
- `busy` out 1: high when state ≠ IDLE.
- `err_sticky` out 1: sticky overrun flag.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE + `reg_en` with `err_sticky`=0:
  - Capture `reg_addr`, `reg_wdata`, and `reg_wr_en` into the `dm_req_*` registers.
  - Clear the timeout counter.
  - Go to REQ.
- IDLE + `reg_en` with `err_sticky`=1:
  - Issue no DM request; stay IDLE.
  - Next cycle: `rsp_status`=3, `rsp_toggle` inverts, `rsp_rdata` unchanged.
- REQ: `dm_req_valid`=1. On `dm_req_valid & dm_req_ready`, go to WAIT; `dm_req_valid` is low from the next cycle.
- WAIT + `dm_rsp_valid`:
  - Complete with `rsp_status`=0.
  - If a read, load `rsp_rdata` from `dm_rsp_rdata`; writes leave `rsp_rdata` unchanged.
  - Go to IDLE.
- `dm_rsp_valid` is ignored in IDLE and REQ; late responses after a timeout are dropped.
- Timeout:
  - The counter (width clog2(TIMEOUT)) increments every cycle in REQ or WAIT.
  - When the count reaches TIMEOUT-1 without a completing event that cycle, complete with `rsp_status`=2 and go to IDLE.
  - A timeout in REQ drops `dm_req_valid` without a handshake.
- Overrun: `reg_en` while state ≠ IDLE:
  - Sets `err_sticky`; the strobe is discarded.
  - The in-flight access continues unaffected.
- `clr_err` clears `err_sticky`. If `clr_err` and an overrun occur in the same cycle, set wins.
- Every completion (success, timeout, sticky-busy) inverts `rsp_toggle` exactly once. `rsp_rdata` and `rsp_status` change only in the same cycle `rsp_toggle` inverts.
- Mid-operation reset: return to IDLE immediately and clear all outputs to their reset values; no toggle is generated.

## Timing
- Reset values: `dm_req_valid` 0, `dm_req_write` 0, `dm_req_addr` 0, `dm_req_wdata` 0, `rsp_rdata` 0, `rsp_status` 0, `rsp_toggle` 0, `busy` 0, `err_sticky` 0.
- All outputs are registered.
- `reg_en` at cycle N gives `dm_req_valid`=1 and `busy`=1 at N+1.
- Handshake at cycle H gives `dm_req_valid`=0 at H+1.
- `dm_rsp_valid` at cycle M ≥ H+1 updates `rsp_*` and `rsp_toggle` at M+1, with `busy`=0 at M+1.
- Minimum round trip with zero-wait DM: `reg_en` N, handshake N+1, response N+2, toggle N+3.
- A new `reg_en` is accepted in the first cycle `busy`=0.
- Sticky-busy completion: `reg_en` N, toggle N+1; `busy` stays 0.
- Timeout: the completion lands TIMEOUT cycles after REQ entry.
- In the timeout cycle, `dm_rsp_valid` in WAIT takes priority and gives status 0. `dm_req_ready` in REQ takes priority: the handshake completes, the state moves to WAIT, and the counter keeps running; the next cycle times out.

## Test plan
- Read, DM ready immediately, rsp at H+1 with rdata 0xDEADBEEF, addr 0x11 -> `dm_req_addr`=0x11, `dm_req_write`=0; at N+3 `rsp_rdata`=0xDEADBEEF, `rsp_status`=0, `rsp_toggle` 0->1.
- Write wdata 0x12345678 after a prior read of 0xA5A5A5A5, `dm_req_ready` delayed 5 cycles -> `dm_req_valid` held 6 cycles, `dm_req_wdata`=0x12345678; `rsp_rdata` stays 0xA5A5A5A5, status 0.
- TIMEOUT=8, DM never responds -> completion 8 cycles after REQ entry with status 2; a late `dm_rsp_valid` afterwards causes no toggle and no data change.
- `reg_en` while WAIT -> `err_sticky`=1 and the original access completes with status 0. A next `reg_en` gives no `dm_req_valid`, and the toggle one cycle later carries status 3. After `clr_err`, the next access proceeds normally.
- `clr_err` coincident with an overrun `reg_en` -> `err_sticky` remains 1.
- `rst_n` asserted in WAIT -> all outputs return to reset values asynchronously. After release, `reg_en` starts a fresh access and the first completion gives `rsp_toggle`=1.
